// File: rtl/segdisplay_arbiter.sv
// segdisplay_arbiter
//   Shares one 8-digit multiplexed 7-segment display among three requesters.
//   A prescaler produces a scan tick every 2^DIV cycles; each digit is blanked
//   for BLANK cycles and then driven until the next tick. Ownership changes only
//   at frame boundaries (after digit 7), with a minimum hold of HOLD frames while
//   the owner keeps requesting. Each frame is latched whole, so it never tears.
//
// Ports
//   clk_peripheral  in   1   single clock
//   reset_n         in   1   asynchronous active-low reset
//   req             in   3   request lines, index 0 highest priority
//   data0..data2    in   40  frames, digit d at [5d+4:5d], d=0 leftmost
//                            (code[4] = decimal point, code[3:0] = hex digit)
//   gnt             out  3   one-hot current owner, 000 = none
//   frame_done      out  1   one-cycle pulse after digit 7 drive ends
//   an              out  8   digit anodes, active-low, an[7] = digit 0
//   ca              out  8   segments, active-low, ca[7] = dp, ca[6:0] = g..a
//
// Scan FSM
//   state   | meaning
//   IDLE    | no owner, display dark, grant on next tick with any request
//   BLANK   | all anodes off for BLANK cycles ahead of digit sel
//   DRIVE   | digit sel lit with its latched code until the next tick

module segdisplay_arbiter #(
    parameter int DIV   = 12,
    parameter int BLANK = 4,
    parameter int HOLD  = 3
) (
    input  logic        clk_peripheral,
    input  logic        reset_n,
    input  logic [2:0]  req,
    input  logic [39:0] data0,
    input  logic [39:0] data1,
    input  logic [39:0] data2,
    output logic [2:0]  gnt,
    output logic        frame_done,
    output logic [7:0]  an,
    output logic [7:0]  ca
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BLANK = 2'd1,
        S_DRIVE = 2'd2
    } state_t;

    localparam logic [DIV-1:0] PRE_ONE    = DIV'(1);
    localparam logic [DIV-1:0] BLANK_LOAD = DIV'(BLANK - 1);
    localparam logic [3:0]     HOLD_L     = 4'(HOLD);

    state_t      state_q, state_d;
    logic [DIV-1:0] pre_q;
    logic [DIV-1:0] blank_q, blank_d;
    logic [2:0]  sel_q, sel_d;
    logic [2:0]  gnt_q, gnt_d;
    logic [3:0]  held_q, held_d;
    logic [39:0] frame_q, frame_d;
    logic        fd_d;
    logic [7:0]  an_d, ca_d;
    logic        tick;
    logic [2:0]  arb_gnt;
    logic        owner_keep;
    logic [3:0]  held_inc;
    logic [4:0]  code;

    function automatic logic [2:0] prio(input logic [2:0] r);
        if (r[0])      return 3'b001;
        else if (r[1]) return 3'b010;
        else if (r[2]) return 3'b100;
        else           return 3'b000;
    endfunction

    function automatic logic [39:0] pick_frame(input logic [2:0]  g,
                                               input logic [39:0] d0,
                                               input logic [39:0] d1,
                                               input logic [39:0] d2);
        case (g)
            3'b001:  return d0;
            3'b010:  return d1;
            3'b100:  return d2;
            default: return 40'd0;
        endcase
    endfunction

    // Active-low segment pattern g..a for a hex digit.
    function automatic logic [6:0] seg7(input logic [3:0] h);
        case (h)
            4'h0: return 7'h40;
            4'h1: return 7'h79;
            4'h2: return 7'h24;
            4'h3: return 7'h30;
            4'h4: return 7'h19;
            4'h5: return 7'h12;
            4'h6: return 7'h02;
            4'h7: return 7'h78;
            4'h8: return 7'h00;
            4'h9: return 7'h10;
            4'hA: return 7'h08;
            4'hB: return 7'h03;
            4'hC: return 7'h46;
            4'hD: return 7'h21;
            4'hE: return 7'h06;
            default: return 7'h0E;
        endcase
    endfunction

    assign tick       = &pre_q;
    assign arb_gnt    = prio(req);
    assign owner_keep = (|(req & gnt_q)) && (held_q < HOLD_L);
    assign held_inc   = (held_q == 4'hF) ? held_q : held_q + 4'd1;

    // State register; an/ca are decoded from the next state so the registered
    // anode and segment code always switch on the same edge.
    always_ff @(posedge clk_peripheral or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            pre_q      <= '0;
            blank_q    <= '0;
            sel_q      <= 3'd0;
            gnt_q      <= 3'b000;
            held_q     <= 4'd0;
            frame_q    <= 40'd0;
            frame_done <= 1'b0;
            an         <= 8'hFF;
            ca         <= 8'hFF;
        end else begin
            state_q    <= state_d;
            pre_q      <= pre_q + PRE_ONE;
            blank_q    <= blank_d;
            sel_q      <= sel_d;
            gnt_q      <= gnt_d;
            held_q     <= held_d;
            frame_q    <= frame_d;
            frame_done <= fd_d;
            an         <= an_d;
            ca         <= ca_d;
        end
    end

    // Next-state and arbitration
    always_comb begin
        state_d = state_q;
        blank_d = blank_q;
        sel_d   = sel_q;
        gnt_d   = gnt_q;
        held_d  = held_q;
        frame_d = frame_q;
        fd_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (tick && (req != 3'b000)) begin
                    gnt_d   = arb_gnt;
                    held_d  = 4'd1;
                    frame_d = pick_frame(arb_gnt, data0, data1, data2);
                    sel_d   = 3'd0;
                    blank_d = BLANK_LOAD;
                    state_d = S_BLANK;
                end
            end
            S_BLANK: begin
                if (blank_q == '0) state_d = S_DRIVE;
                else               blank_d = blank_q - PRE_ONE;
            end
            S_DRIVE: begin
                if (tick) begin
                    if (sel_q != 3'd7) begin
                        sel_d   = sel_q + 3'd1;
                        blank_d = BLANK_LOAD;
                        state_d = S_BLANK;
                    end else begin
                        fd_d  = 1'b1;
                        sel_d = 3'd0;
                        if (owner_keep) begin
                            held_d  = held_inc;
                            frame_d = pick_frame(gnt_q, data0, data1, data2);
                            blank_d = BLANK_LOAD;
                            state_d = S_BLANK;
                        end else if (req != 3'b000) begin
                            // HOLD is ignored here: either it expired or the
                            // owner has dropped its request.
                            gnt_d   = arb_gnt;
                            held_d  = (arb_gnt == gnt_q) ? held_inc : 4'd1;
                            frame_d = pick_frame(arb_gnt, data0, data1, data2);
                            blank_d = BLANK_LOAD;
                            state_d = S_BLANK;
                        end else begin
                            gnt_d   = 3'b000;
                            held_d  = 4'd0;
                            state_d = S_IDLE;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode from next state
    always_comb begin
        an_d = 8'hFF;
        ca_d = 8'hFF;
        code = frame_d[5*sel_d +: 5];
        if (state_d == S_DRIVE) begin
            an_d = ~(8'h80 >> sel_d);
            ca_d = {~code[4], seg7(code[3:0])};
        end
    end

    assign gnt = gnt_q;

endmodule

// File: tb/tb_segdisplay_arbiter.sv
module tb_segdisplay_arbiter;

    logic        clk_peripheral = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  req = 3'b000;
    logic [39:0] data0 = 40'd0;
    logic [39:0] data1 = 40'd0;
    logic [39:0] data2 = 40'd0;
    logic [2:0]  gnt;
    logic        frame_done;
    logic [7:0]  an;
    logic [7:0]  ca;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0] an_exp [8] = '{8'h7F, 8'hBF, 8'hDF, 8'hEF, 8'hF7, 8'hFB, 8'hFD, 8'hFE};
    logic [7:0] ca_exp [8] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8};

    segdisplay_arbiter #(.DIV(4), .BLANK(2), .HOLD(2)) dut (
        .clk_peripheral(clk_peripheral),
        .reset_n(reset_n),
        .req(req),
        .data0(data0),
        .data1(data1),
        .data2(data2),
        .gnt(gnt),
        .frame_done(frame_done),
        .an(an),
        .ca(ca)
    );

    always #5 clk_peripheral = ~clk_peripheral;

    task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after edge e, counting edges from reset release.
    task automatic step_to(input int e);
        while (cyc < e) begin
            @(posedge clk_peripheral);
            #1;
            cyc++;
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        @(posedge clk_peripheral);
        #1;
        reset_n = 1'b1;
        cyc = 0;
    endtask

    function automatic logic [39:0] fill(input logic [4:0] c);
        return {8{c}};
    endfunction

    initial begin
        // Scenario A: single requester, digit walk and blanking
        req = 3'b001;
        for (int d = 0; d < 8; d++) data0[5*d +: 5] = 5'(d);
        @(posedge clk_peripheral);
        #1;
        chk("rst_an", an, 8'hFF);
        chk("rst_ca", ca, 8'hFF);
        chk("rst_gnt", gnt, 3'b000);
        chk("rst_fd", frame_done, 1'b0);
        do_reset();
        step_to(15);
        chk("A_pre_tick_gnt", gnt, 3'b000);
        step_to(16);
        chk("A_grant", gnt, 3'b001);
        chk("A_blank0_a", an, 8'hFF);
        step_to(17);
        chk("A_blank0_b", an, 8'hFF);
        step_to(18);
        chk("A_an0", an, an_exp[0]);
        chk("A_ca0", ca, ca_exp[0]);
        for (int d = 1; d < 8; d++) begin
            step_to(16 + 16*d);
            chk("A_blank_a", an, 8'hFF);
            step_to(17 + 16*d);
            chk("A_blank_b", an, 8'hFF);
            step_to(18 + 16*d);
            chk("A_an", an, an_exp[d]);
            chk("A_ca", ca, ca_exp[d]);
        end
        step_to(143);
        chk("A_d7_end_an", an, 8'hFE);
        chk("A_fd_early", frame_done, 1'b0);
        step_to(144);
        chk("A_fd", frame_done, 1'b1);
        chk("A_bnd_an", an, 8'hFF);
        chk("A_bnd_gnt", gnt, 3'b001);
        step_to(145);
        chk("A_fd_pulse", frame_done, 1'b0);

        // Scenario B: owner req0 drops mid frame 1, req1 takes over at boundary
        req = 3'b011;
        data0 = fill(5'h05);
        data1 = fill(5'h0C);
        do_reset();
        step_to(16);
        chk("B_gnt0", gnt, 3'b001);
        step_to(80);
        req = 3'b010;
        step_to(143);
        chk("B_gnt_hold", gnt, 3'b001);
        chk("B_finish_frame_ca", ca, 8'h92);
        step_to(144);
        chk("B_gnt_switch", gnt, 3'b010);
        step_to(146);
        chk("B_new_an", an, 8'h7F);
        chk("B_new_ca", ca, 8'hC6);

        // Scenario C: req0 rises mid frame 1, waits for HOLD expiry
        req = 3'b100;
        data0 = fill(5'h01);
        data2 = fill(5'h0E);
        do_reset();
        step_to(16);
        chk("C_gnt2", gnt, 3'b100);
        step_to(80);
        req = 3'b101;
        step_to(144);
        chk("C_hold_gnt", gnt, 3'b100);
        step_to(146);
        chk("C_f2_ca", ca, 8'h86);
        step_to(271);
        chk("C_f2_end_gnt", gnt, 3'b100);
        step_to(272);
        chk("C_switch_gnt", gnt, 3'b001);
        step_to(274);
        chk("C_new_an", an, 8'h7F);
        chk("C_new_ca", ca, 8'hF9);

        // Scenario D: no tearing when data changes mid-frame
        req = 3'b001;
        data0 = fill(5'h03);
        do_reset();
        step_to(50);
        chk("D_d2_ca", ca, 8'hB0);
        data0 = fill(5'h07);
        step_to(51);
        chk("D_no_tear_a", ca, 8'hB0);
        step_to(143);
        chk("D_no_tear_b", ca, 8'hB0);
        step_to(146);
        chk("D_next_frame", ca, 8'hF8);

        // Scenario E: all requests drop, display goes dark until next tick
        step_to(200);
        req = 3'b000;
        step_to(272);
        chk("E_fd", frame_done, 1'b1);
        chk("E_gnt", gnt, 3'b000);
        chk("E_an", an, 8'hFF);
        chk("E_ca", ca, 8'hFF);
        step_to(273);
        chk("E_fd_low", frame_done, 1'b0);
        step_to(300);
        chk("E_idle_an", an, 8'hFF);
        req = 3'b001;
        step_to(303);
        chk("E_wait_tick", gnt, 3'b000);
        step_to(304);
        chk("E_regrant", gnt, 3'b001);
        step_to(306);
        chk("E_re_an", an, 8'h7F);
        chk("E_re_ca", ca, 8'hF8);

        // Scenario F: async reset during DRIVE sel=4
        req = 3'b001;
        data0 = 40'd0;
        data0[24:20] = 5'h13;
        do_reset();
        step_to(82);
        chk("F_sel4_an", an, 8'hF7);
        chk("F_sel4_ca", ca, 8'h30);
        reset_n = 1'b0;
        #1;
        chk("F_async_an", an, 8'hFF);
        chk("F_async_ca", ca, 8'hFF);
        chk("F_async_gnt", gnt, 3'b000);
        do_reset();
        step_to(15);
        chk("F_post_pre", gnt, 3'b000);
        step_to(18);
        chk("F_post_gnt", gnt, 3'b001);
        chk("F_post_an", an, 8'h7F);
        chk("F_post_ca", ca, 8'hC0);
        step_to(82);
        chk("F_post_sel4_ca", ca, 8'h30);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
